// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues in-order word fetches to instruction memory,
// buffers returned words in a small FIFO and hands {instruction, pc} to decode.
// A redirect flushes the buffer and arranges for in-flight responses to be dropped.
module instruction_fetch_unit #(
  parameter int unsigned                ADDRESS_WIDTH = 32,
  parameter int unsigned                BUFFER_DEPTH  = 2,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0
) (
  input  logic                     clock,
  input  logic                     reset_n,
  // Memory request (valid/ready)
  output logic                     imem_request_valid,
  input  logic                     imem_request_ready,
  output logic [ADDRESS_WIDTH-1:0] imem_address,
  // Memory response (valid only, in order)
  input  logic                     imem_response_valid,
  input  logic [31:0]              imem_response_data,
  // Decode side (valid/ready)
  output logic                     instruction_valid,
  input  logic                     instruction_ready,
  output logic [31:0]              instruction,
  output logic [ADDRESS_WIDTH-1:0] instruction_pc,
  // Redirect from decode/execute
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirect_target
);

  localparam int unsigned PtrWidth     = $clog2(BUFFER_DEPTH);
  localparam int unsigned CountWidth   = PtrWidth + 1;
  // Discards can pile up across back-to-back redirects; 8 bits is far beyond any real backlog.
  localparam int unsigned DiscardWidth = 8;
  localparam logic [CountWidth:0] DepthCredits = (CountWidth + 1)'(BUFFER_DEPTH);

  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;

  logic [31:0]              fifo_data_q [BUFFER_DEPTH];
  logic [ADDRESS_WIDTH-1:0] fifo_pc_q   [BUFFER_DEPTH];
  logic [PtrWidth-1:0]      fifo_wr_q, fifo_wr_d;
  logic [PtrWidth-1:0]      fifo_rd_q, fifo_rd_d;
  logic [CountWidth-1:0]    count_q, count_d;

  // Addresses of accepted-but-unanswered requests, so each kept response gets its PC.
  logic [ADDRESS_WIDTH-1:0] addr_queue_q [BUFFER_DEPTH];
  logic [PtrWidth-1:0]      aq_wr_q, aq_wr_d;
  logic [PtrWidth-1:0]      aq_rd_q, aq_rd_d;
  logic [CountWidth-1:0]    outstanding_q, outstanding_d;

  logic [DiscardWidth-1:0]  discard_q, discard_d;

  logic [CountWidth:0]      credit_used;
  logic                     accept;
  logic                     resp_drop;
  logic                     resp_keep;
  logic                     push;
  logic                     pop;

  // Handshake decode and combinational outputs
  always_comb begin
    credit_used        = {1'b0, count_q} + {1'b0, outstanding_q};
    // reset_n gate keeps the request low while the counters sit at their reset values
    imem_request_valid = reset_n && !redirect && (credit_used < DepthCredits);
    imem_address       = pc_q;
    accept             = imem_request_valid && imem_request_ready;
    resp_drop          = imem_response_valid && (discard_q != '0);
    resp_keep          = imem_response_valid && (discard_q == '0);
    push               = resp_keep && !redirect;
    instruction_valid  = (count_q != '0);
    pop                = instruction_valid && instruction_ready;
    instruction        = instruction_valid ? fifo_data_q[fifo_rd_q] : '0;
    instruction_pc     = instruction_valid ? fifo_pc_q[fifo_rd_q] : '0;
  end

  // Next-state for PC, pointers and counters; redirect overrides everything
  always_comb begin
    pc_d          = pc_q;
    fifo_wr_d     = fifo_wr_q;
    fifo_rd_d     = fifo_rd_q;
    count_d       = count_q;
    aq_wr_d       = aq_wr_q;
    aq_rd_d       = aq_rd_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q - DiscardWidth'(resp_drop);

    if (redirect) begin
      pc_d          = redirect_target;
      fifo_wr_d     = '0;
      fifo_rd_d     = '0;
      count_d       = '0;
      aq_wr_d       = '0;
      aq_rd_d       = '0;
      outstanding_d = '0;
      // Everything still in flight (minus a response landing now) must be dropped later.
      discard_d     = discard_d + DiscardWidth'(outstanding_q) - DiscardWidth'(resp_keep);
    end else begin
      if (accept) begin
        pc_d    = pc_q + ADDRESS_WIDTH'(4);
        aq_wr_d = aq_wr_q + PtrWidth'(1);
      end
      if (resp_keep) begin
        aq_rd_d = aq_rd_q + PtrWidth'(1);
      end
      if (push) begin
        fifo_wr_d = fifo_wr_q + PtrWidth'(1);
      end
      if (pop) begin
        fifo_rd_d = fifo_rd_q + PtrWidth'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CountWidth'(1);
        2'b01:   count_d = count_q - CountWidth'(1);
        default: count_d = count_q;
      endcase
      unique case ({accept, resp_keep})
        2'b10:   outstanding_d = outstanding_q + CountWidth'(1);
        2'b01:   outstanding_d = outstanding_q - CountWidth'(1);
        default: outstanding_d = outstanding_q;
      endcase
    end
  end

  // Control state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q          <= RESET_PC;
      fifo_wr_q     <= '0;
      fifo_rd_q     <= '0;
      count_q       <= '0;
      aq_wr_q       <= '0;
      aq_rd_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      fifo_wr_q     <= fifo_wr_d;
      fifo_rd_q     <= fifo_rd_d;
      count_q       <= count_d;
      aq_wr_q       <= aq_wr_d;
      aq_rd_q       <= aq_rd_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // Storage arrays; contents only matter once qualified by the counters
  always_ff @(posedge clock) begin
    if (accept) begin
      addr_queue_q[aq_wr_q] <= pc_q;
    end
    if (push) begin
      fifo_data_q[fifo_wr_q] <= imem_response_data;
      fifo_pc_q[fifo_wr_q]   <= addr_queue_q[aq_rd_q];
    end
  end

endmodule
